// File: rtl/fir_out_serializer.sv
// Buffers 3-parallel FIR output triplets and emits them one sample per transfer.
// Optional overflow status (OVF, DROP_CNT) is enabled by defining SER_OVF_STATUS_EN.
module fir_out_serializer #(
  parameter int unsigned NBIT  = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            VIN,
  input  logic [NBIT-1:0] DIN3k,
  input  logic [NBIT-1:0] DIN3k1,
  input  logic [NBIT-1:0] DIN3k2,
  input  logic            READY,
  output logic [NBIT-1:0] DOUT,
  output logic            VOUT,
  output logic            FULL
`ifdef SER_OVF_STATUS_EN
  ,
  output logic            OVF,
  output logic [7:0]      DROP_CNT
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = 3 * NBIT;

  typedef enum logic [1:0] {
    PH_0 = 2'd0,
    PH_1 = 2'd1,
    PH_2 = 2'd2
  } phase_t;

  logic [TW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  phase_t        phase_q;
  phase_t        phase_d;

  logic [TW-1:0]   head;
  logic [NBIT-1:0] dout_c;
  logic            vout_c;
  logic            full_c;
  logic            transfer;
  logic            pop;
  logic            wr;
  logic            drop;

  // Handshake, buffer control and output sample selection
  always_comb begin
    vout_c   = 1'b0;
    full_c   = 1'b0;
    transfer = 1'b0;
    pop      = 1'b0;
    wr       = 1'b0;
    drop     = 1'b0;
    phase_d  = phase_q;
    dout_c   = '0;
    head     = mem[rptr];

    vout_c   = (count != '0);
    full_c   = (count == CW'(DEPTH));
    transfer = vout_c & READY;
    pop      = transfer & (phase_q == PH_2);
    wr       = VIN & (~full_c | pop);
    drop     = VIN & full_c & ~pop;

    if (transfer) begin
      case (phase_q)
        PH_0:    phase_d = PH_1;
        PH_1:    phase_d = PH_2;
        default: phase_d = PH_0;
      endcase
    end

    if (vout_c) begin
      case (phase_q)
        PH_0:    dout_c = head[NBIT-1:0];
        PH_1:    dout_c = head[2*NBIT-1:NBIT];
        default: dout_c = head[3*NBIT-1:2*NBIT];
      endcase
    end
  end

  assign DOUT = dout_c;
  assign VOUT = vout_c;
  assign FULL = full_c;

  // Phase register
  always_ff @(posedge CLK) begin
    if (RST) phase_q <= PH_0;
    else     phase_q <= phase_d;
  end

  // Pointers and occupancy; a write while full relies on the same-cycle pop
  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr)  wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      case ({wr, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; DOUT is masked while the buffer is empty
  always_ff @(posedge CLK) begin
    if (!RST && wr) mem[wptr] <= {DIN3k2, DIN3k1, DIN3k};
  end

`ifdef SER_OVF_STATUS_EN
  // Sticky overflow flag and saturating drop counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      OVF      <= 1'b0;
      DROP_CNT <= 8'd0;
    end else if (drop) begin
      OVF <= 1'b1;
      if (DROP_CNT != 8'hFF) DROP_CNT <= DROP_CNT + 8'd1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_fir_out_serializer.sv
// Directed self-checking bench for fir_out_serializer (NBIT=8, DEPTH=4).
module tb_fir_out_serializer;

  localparam int unsigned NBIT  = 8;
  localparam int unsigned DEPTH = 4;

  logic            CLK = 1'b0;
  logic            RST;
  logic            VIN;
  logic [NBIT-1:0] DIN3k;
  logic [NBIT-1:0] DIN3k1;
  logic [NBIT-1:0] DIN3k2;
  logic            READY;
  logic [NBIT-1:0] DOUT;
  logic            VOUT;
  logic            FULL;
`ifdef SER_OVF_STATUS_EN
  logic            OVF;
  logic [7:0]      DROP_CNT;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  fir_out_serializer #(.NBIT(NBIT), .DEPTH(DEPTH)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .VIN      (VIN),
    .DIN3k    (DIN3k),
    .DIN3k1   (DIN3k1),
    .DIN3k2   (DIN3k2),
    .READY    (READY),
    .DOUT     (DOUT),
    .VOUT     (VOUT),
    .FULL     (FULL)
`ifdef SER_OVF_STATUS_EN
    ,
    .OVF      (OVF),
    .DROP_CNT (DROP_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_triplet(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    VIN = 1'b1; DIN3k = a; DIN3k1 = b; DIN3k2 = c;
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] e;
  int         sent;
  int         cyc;

  initial begin
    RST = 1'b1; VIN = 1'b0; READY = 1'b0;
    DIN3k = '0; DIN3k1 = '0; DIN3k2 = '0;

    // Reset state
    step(); step();
    RST = 1'b0;
    check("rst_vout", 32'(VOUT), 32'd0);
    check("rst_dout", 32'(DOUT), 32'd0);
    check("rst_full", 32'(FULL), 32'd0);
`ifdef SER_OVF_STATUS_EN
    check("rst_ovf",  32'(OVF), 32'd0);
    check("rst_drop", 32'(DROP_CNT), 32'd0);
`endif

    // Single triplet, READY=1
    READY = 1'b1;
    drive_triplet(8'h11, 8'h22, 8'h33);
    step();
    VIN = 1'b0;
    check("t1_vout0", 32'(VOUT), 32'd1);
    check("t1_s0", 32'(DOUT), 32'h11);
    step(); check("t1_s1", 32'(DOUT), 32'h22);
    step(); check("t1_s2", 32'(DOUT), 32'h33);
    step();
    check("t1_empty_vout", 32'(VOUT), 32'd0);
    check("t1_empty_dout", 32'(DOUT), 32'd0);

    // Same triplet with READY held low for 5 cycles
    READY = 1'b0;
    drive_triplet(8'h11, 8'h22, 8'h33);
    step();
    VIN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_vout", 32'(VOUT), 32'd1);
      check("t2_hold_dout", 32'(DOUT), 32'h11);
      if (i < 4) step();
    end
    READY = 1'b1;
    step(); check("t2_s1", 32'(DOUT), 32'h22);
    step(); check("t2_s2", 32'(DOUT), 32'h33);
    step(); check("t2_empty", 32'(VOUT), 32'd0);

    // Fill to full with READY=0; the fifth triplet is dropped
    READY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_triplet(8'(8'h40 + 16 * i), 8'(8'h41 + 16 * i), 8'(8'h42 + 16 * i));
      step();
      check("t3_full", 32'(FULL), (i == 3) ? 32'd1 : 32'd0);
    end
    drive_triplet(8'hE0, 8'hE1, 8'hE2);
    step();
    VIN = 1'b0;
    check("t3_full_after_drop", 32'(FULL), 32'd1);
    check("t3_head", 32'(DOUT), 32'h40);
`ifdef SER_OVF_STATUS_EN
    check("t3_ovf",  32'(OVF), 32'd1);
    check("t3_drop", 32'(DROP_CNT), 32'd1);
`endif

    // Full at phase 2 with READY=1: simultaneous write is accepted
    READY = 1'b1;
    step(); check("t4_p1", 32'(DOUT), 32'h41);
    step(); check("t4_p2", 32'(DOUT), 32'h42);
    drive_triplet(8'hA0, 8'hA1, 8'hA2);
    step();
    VIN = 1'b0;
    check("t4_full_kept", 32'(FULL), 32'd1);
`ifdef SER_OVF_STATUS_EN
    check("t4_no_drop", 32'(DROP_CNT), 32'd1);
`endif
    exp_q = {8'h50, 8'h51, 8'h52, 8'h60, 8'h61, 8'h62,
             8'h70, 8'h71, 8'h72, 8'hA0, 8'hA1, 8'hA2};
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("t4_drain_vout", 32'(VOUT), 32'd1);
      check("t4_drain_dout", 32'(DOUT), 32'(e));
      step();
    end
    check("t4_empty", 32'(VOUT), 32'd0);

    // Reset at phase 1 with 3 triplets buffered; VIN during reset is ignored
    READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_triplet(8'(8'hB0 + 16 * i), 8'(8'hB1 + 16 * i), 8'(8'hB2 + 16 * i));
      step();
    end
    VIN = 1'b0;
    READY = 1'b1;
    step();
    check("t5_phase1", 32'(DOUT), 32'hB1);
    RST = 1'b1;
    drive_triplet(8'hEE, 8'hEE, 8'hEE);
    step();
    RST = 1'b0; VIN = 1'b0;
    check("t5_rst_vout", 32'(VOUT), 32'd0);
    check("t5_rst_dout", 32'(DOUT), 32'd0);
    check("t5_rst_full", 32'(FULL), 32'd0);
    drive_triplet(8'h01, 8'h02, 8'h03);
    step();
    VIN = 1'b0;
    check("t5_new_s0", 32'(DOUT), 32'h01);
    step(); check("t5_new_s1", 32'(DOUT), 32'h02);
    step(); check("t5_new_s2", 32'(DOUT), 32'h03);
    step(); check("t5_empty", 32'(VOUT), 32'd0);

    // 12 triplets with random READY against the serial reference sequence
    void'($urandom(32'd12345));
    sent = 0;
    cyc  = 0;
    while ((sent < 12 || exp_q.size() > 0) && cyc < 400) begin
      READY = 1'($urandom_range(1, 0));
      if (sent < 12 && !FULL) begin
        drive_triplet(8'(3 * sent), 8'(3 * sent + 1), 8'(3 * sent + 2));
        exp_q.push_back(8'(3 * sent));
        exp_q.push_back(8'(3 * sent + 1));
        exp_q.push_back(8'(3 * sent + 2));
        sent++;
      end else begin
        VIN = 1'b0;
      end
      if (VOUT && READY) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("t6_stream", 32'(DOUT), 32'(e));
        end else begin
          check("t6_spurious_vout", 32'(VOUT), 32'd0);
        end
      end else if (!VOUT) begin
        check("t6_idle_dout", 32'(DOUT), 32'd0);
      end
      step();
      cyc++;
    end
    VIN = 1'b0;
    check("t6_timeout", 32'(cyc < 400), 32'd1);
    check("t6_all_sent", 32'(sent), 32'd12);
    check("t6_final_empty", 32'(VOUT), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
